serpario_ctrl: RTL

//  Controller for the external serial/parallel I/O expander chain (74HC595 out, shift-in via SER_IN).

---
 rtl/serpario_pkg.sv | 20 ++
 rtl/serpario_ctrl_if.sv | 28 ++
 rtl/serpario_tick.sv | 38 +++
 rtl/serpario_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serpario_pkg.sv
// Shared types and sizing helpers for the serpario expander-chain controller.
package serpario_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STORE = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam int unsigned DEF_N_BITS  = 16;
   localparam int unsigned DEF_CLK_DIV = 4;
   localparam int unsigned REFRESH_W   = 32;

   // Bits needed to hold the values 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/serpario_ctrl_if.sv
// Host-side bus of the serpario controller: launch handshake, write word, read word, status.
interface serpario_ctrl_if
   import serpario_pkg::*;
#(
   parameter int unsigned N_BITS = DEF_N_BITS
);
   logic              start;
   logic [N_BITS-1:0] wr_data;
   logic [N_BITS-1:0] rd_data;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output wr_data,
      input  rd_data,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  wr_data,
      output rd_data,
      output busy,
      output done
   );
endinterface

// File: rtl/serpario_tick.sv
// Half-period prescaler for the chain shift clock: tick_o marks the last clk_i cycle
// of every CLK_DIV-cycle window; clear_i holds the window at its start.
module serpario_tick
   import serpario_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic reset_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned   CW   = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serpario_ctrl.sv
// Sequencer for the 74HC595/shift-in expander chain: shifts one word out MSB first while
// capturing the returned word, strobes the output latch, and optionally refreshes when idle.
module serpario_ctrl
   import serpario_pkg::*;
#(
   parameter int unsigned N_BITS         = DEF_N_BITS,
   parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
   parameter int unsigned REFRESH_CYCLES = 0
) (
   input  logic           clk_i,
   input  logic           reset_n,
   serpario_ctrl_if.slave bus,
   input  logic           ser_in,
   output logic           ser_out,
   output logic           sh_clk,
   output logic           store,
   output logic           out_en
);

   localparam int unsigned          IW       = cnt_width(N_BITS);
   localparam logic [IW-1:0]        LAST_BIT = IW'(N_BITS - 1);
   localparam logic [REFRESH_W-1:0] REF_LAST = REFRESH_W'(REFRESH_CYCLES - 1);

   state_e                 state_q,   state_d;
   logic [IW-1:0]          bit_idx_q, bit_idx_d;
   logic                   phase_q,   phase_d;
   logic                   sh_clk_q,  sh_clk_d;
   logic                   store_q,   store_d;
   logic                   ser_out_q, ser_out_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;
   logic                   out_en_q,  out_en_d;
   logic [N_BITS-1:0]      rd_data_q, rd_data_d;
   logic [N_BITS-1:0]      shadow_q,  shadow_d;
   logic [N_BITS-1:0]      out_sr_q,  out_sr_d;
   logic [N_BITS-1:0]      in_sr_q,   in_sr_d;
   logic [REFRESH_W-1:0]   ref_cnt_q, ref_cnt_d;

   logic                   tick;
   logic                   tick_clear;
   logic                   host_acc;
   logic                   expire;
   logic                   accept;
   logic [N_BITS-1:0]      load_word;

   serpario_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .clear_i (tick_clear),
      .tick_o  (tick)
   );

   assign tick_clear = (state_q == IDLE) || (state_q == FIN);

   // A host start always beats a coincident refresh expiry; both load through load_word.
   assign host_acc  = bus.start && ((state_q == IDLE) || (state_q == FIN));
   assign expire    = (REFRESH_CYCLES != 0) && (state_q == IDLE) && (ref_cnt_q == REF_LAST);
   assign accept    = host_acc || expire;
   assign load_word = bus.start ? bus.wr_data : shadow_q;

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      phase_d   = phase_q;
      sh_clk_d  = sh_clk_q;
      store_d   = store_q;
      ser_out_d = ser_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      out_en_d  = out_en_q;
      rd_data_d = rd_data_q;
      shadow_d  = shadow_q;
      out_sr_d  = out_sr_q;
      in_sr_d   = in_sr_q;
      ref_cnt_d = ref_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (REFRESH_CYCLES != 0) begin
               ref_cnt_d = ref_cnt_q + 32'd1;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!phase_q) begin
                  sh_clk_d = 1'b1;
                  phase_d  = 1'b1;
                  in_sr_d  = (in_sr_q << 1) | N_BITS'(ser_in);
               end else begin
                  sh_clk_d = 1'b0;
                  phase_d  = 1'b0;
                  if (bit_idx_q == LAST_BIT) begin
                     state_d = STORE;
                     store_d = 1'b1;
                  end else begin
                     // Next bit is presented on the same edge that drops sh_clk.
                     bit_idx_d = bit_idx_q + 1'b1;
                     out_sr_d  = out_sr_q << 1;
                     ser_out_d = out_sr_d[N_BITS-1];
                  end
               end
            end
         end
         STORE: begin
            if (tick) begin
               state_d   = FIN;
               store_d   = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               rd_data_d = in_sr_q;
               out_en_d  = 1'b0;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d   = SHIFT;
         bit_idx_d = '0;
         phase_d   = 1'b0;
         sh_clk_d  = 1'b0;
         store_d   = 1'b0;
         busy_d    = 1'b1;
         shadow_d  = load_word;
         out_sr_d  = load_word;
         ser_out_d = load_word[N_BITS-1];
         in_sr_d   = '0;
         ref_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         phase_q   <= 1'b0;
         sh_clk_q  <= 1'b0;
         store_q   <= 1'b0;
         ser_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         out_en_q  <= 1'b1;
         rd_data_q <= '0;
         shadow_q  <= '0;
         out_sr_q  <= '0;
         in_sr_q   <= '0;
         ref_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         phase_q   <= phase_d;
         sh_clk_q  <= sh_clk_d;
         store_q   <= store_d;
         ser_out_q <= ser_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         out_en_q  <= out_en_d;
         rd_data_q <= rd_data_d;
         shadow_q  <= shadow_d;
         out_sr_q  <= out_sr_d;
         in_sr_q   <= in_sr_d;
         ref_cnt_q <= ref_cnt_d;
      end
   end

   assign ser_out     = ser_out_q;
   assign sh_clk      = sh_clk_q;
   assign store       = store_q;
   assign out_en      = out_en_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_data = rd_data_q;

endmodule
